hexscan_display: RTL and testbench
==================================

Name: hexscan_display

Overview:
- Parametrised successor to the fixed 4-digit hex segment driver.
- Time-multiplexes DIGITS common-cathode 7-segment digits plus decimal points from one snapshot of a packed hex value.
- Adds PWM brightness, leading-zero blanking, per-digit enable and tear-free frame snapshots.
- Sits between status/debug registers and the board's segment/digit-select pins.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- CLK_HZ, 50000000, input clock frequency.
- REFRESH_HZ, 1000, full-frame refresh rate.
- BRIGHT_BITS, 4, brightness resolution; 2^BRIGHT_BITS PWM sub-phases per slot.

Ports:
- clk  in  1  system clock.
- rstbtn  in  1  asynchronous, active-low reset.
- value  in  4*DIGITS  packed nybbles; digit 0 = value[3:0], LSD.
- dots  in  DIGITS  per-digit decimal point request.
- digit_en  in  DIGITS  per-digit enable; 0 forces that digit dark.
- brightness  in  BRIGHT_BITS  PWM duty code; 0 = dark.
- lz_blank  in  1  1 = blank leading zero digits.
- segment  out  7  bit0=a … bit6=g, active high.
- dp  out  1  decimal point, active high.
- digitsel  out  DIGITS  one-cold digit select, active low.
- frame_tick  out  1  one-cycle pulse at the start of each frame.

Behaviour:
- Reset values: segment=0, dp=0, digitsel=all 1, frame_tick=0; slot counter, digit index and snapshot all 0.
- Timing constants:
  - SLOT = CLK_HZ/(REFRESH_HZ*DIGITS) clocks per digit.
  - SLOT must be a multiple of 2^BRIGHT_BITS and ≥ 2^BRIGHT_BITS; otherwise elaboration fails via a generate-time error.
  - SUB = SLOT >> BRIGHT_BITS.
- Counters:
  - Slot counter s runs 0..SLOT-1.
  - On wrap, digit index d increments 0..DIGITS-1 and wraps to 0.
- Snapshot:
  - When s=SLOT-1 and d=DIGITS-1 (end of frame), value, dots, digit_en, lz_blank and brightness are captured into shadow registers.
  - Outputs for the whole next frame use only shadows; mid-frame input changes never tear the display.
- frame_tick pulses in the first cycle of the frame: registered, coincident with s=0, d=0 outputs.
- PWM:
  - sub = s / SUB.
  - Digit d is driven when sub < shadow brightness.
  - Max code gives (2^B-1)/2^B duty; the final sub-phase is always dark, which provides the anti-ghosting gap.
- Digit d displayed iff all of:
  - PWM on;
  - digit_en[d];
  - not leading-blanked.
- Leading-zero blanking, when lz_blank=1:
  - Digit k is blanked if its nybble and every higher nybble are 0.
  - Digit 0 is never blanked, so all-zero shows "0".
  - The dp of a blanked digit is still shown.
- Dark digit: segment=0, dp=0, digitsel=all 1.
- Lit digit:
  - digitsel has only bit d low.
  - segment = hex decode of nybble d.
  - dp = dots[d].
- All outputs are registered: one clock latency from counter state to pins.
- Segment and digitsel change in the same cycle; no overlap between digits.
- Hex patterns (gfedcba):
  - 0..7 = 3F 06 5B 4F 66 6D 7D 07
  - 8..F = 7F 6F 77 7C 39 5E 79 71
- Reset mid-frame: outputs go to reset values immediately; the first frame after release shows zeros/dark until the first snapshot.

Optional Feature:
- Macro HEXSCAN_BLINK_EN.
- With the macro:
  - Adds input blink[DIGITS-1:0], snapshotted with the other inputs.
  - Adds parameter BLINK_FRAMES (default 500).
  - A frame counter toggles blink phase every BLINK_FRAMES frames; phase resets to on.
  - Digits with blink set are dark during the off phase.
- Without the macro: no blink port or counter; behaviour is as above.

Decomposition:
- Package hexscan_pkg holds:
  - segment pattern constant array HEX7[16];
  - segment bit-index constants;
  - function clog2_safe.
- One sub-module, hexseg_decode: combinational nybble → 7-bit pattern, shared with the single-digit driver.
- Counters, PWM, blanking and snapshot stay in hexscan_display.

Test Plan:
- Bench configuration for all scenarios: DIGITS=4, CLK_HZ=16000, REFRESH_HZ=250, BRIGHT_BITS=4, giving SLOT=16 and SUB=1.
- Scenario 1:
  - Stimulus: reset asserted mid-frame, then released; value=16'h12AF, brightness=15, digit_en=F.
  - Response: immediate reset values; after the first snapshot, digitsel cycles E,D,B,7 every 16 clocks with segments 71,77,5B,06, each lit 15 of 16 clocks.
- Scenario 2:
  - Stimulus: brightness=4.
  - Response: each digit is lit exactly 4 clocks (s=0..3 plus 1 latency), dark for the other 12; brightness=0 keeps digitsel=F permanently.
- Scenario 3:
  - Stimulus: lz_blank=1 with value=16'h0050, then 16'h0000, then 16'h0100 + dots=4'b1000.
  - Response:
    - 0050: digits 3,2 dark; digits 1,0 show 6D,3F.
    - 0000: only digit 0 shows 3F.
    - 0100: digit 3 shows dp only; digits 2..0 show 06,3F,3F.
- Scenario 4:
  - Stimulus: value changes 16'h1111→16'h2222 at s=7, d=2.
  - Response: the remainder of that frame still shows 06; 5B appears only from the next frame_tick onward.
- Scenario 5:
  - Stimulus: digit_en=4'b0101.
  - Response: digitsel never drives bits 1 or 3 low; frame_tick pulses exactly every 64 clocks.
- Scenario 6 (HEXSCAN_BLINK_EN, BLINK_FRAMES=2):
  - Stimulus: blink=4'b0001.
  - Response: digit 0 is lit for 2 frames, dark for 2 frames, repeating; other digits are unaffected.

Source files
------------

// File: rtl/hexscan_pkg.sv
// Shared constants for the hex segment drivers: glyph table, segment bit positions and a width helper.
package hexscan_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;
    localparam int SEG_W = 7;

    // Glyphs for 0..F, bit6..bit0 = g f e d c b a.
    localparam logic [SEG_W-1:0] HEX7 [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hexseg_decode.sv
// Nybble to 7-segment glyph decoder; shared by the single-digit and multiplexed drivers.
module hexseg_decode
    import hexscan_pkg::*;
(
    input  logic [3:0]       i_nybble,
    output logic [SEG_W-1:0] o_seg
);

    logic [SEG_W-1:0] w_pat;

    assign w_pat = HEX7[i_nybble];
    assign o_seg = {w_pat[SEG_G], w_pat[SEG_F], w_pat[SEG_E], w_pat[SEG_D],
                    w_pat[SEG_C], w_pat[SEG_B], w_pat[SEG_A]};

endmodule

// File: rtl/hexscan_display.sv
// Time-multiplexed DIGITS-wide hex display driver: PWM brightness, leading-zero blanking, per-digit
// enable and frame-latched inputs. Define HEXSCAN_BLINK_EN to add the per-digit blink input.
module hexscan_display
    import hexscan_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int CLK_HZ       = 50000000,
    parameter int REFRESH_HZ   = 1000,
    parameter int BRIGHT_BITS  = 4
`ifdef HEXSCAN_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 500
`endif
) (
    input  logic                   clk,
    input  logic                   rstbtn,
    input  logic [4*DIGITS-1:0]    value,
    input  logic [DIGITS-1:0]      dots,
    input  logic [DIGITS-1:0]      digit_en,
    input  logic [BRIGHT_BITS-1:0] brightness,
    input  logic                   lz_blank,
`ifdef HEXSCAN_BLINK_EN
    input  logic [DIGITS-1:0]      blink,
`endif
    output logic [SEG_W-1:0]       segment,
    output logic                   dp,
    output logic [DIGITS-1:0]      digitsel,
    output logic                   frame_tick
);

    localparam int PWM_N = 1 << BRIGHT_BITS;
    localparam int SLOT  = CLK_HZ / (REFRESH_HZ * DIGITS);
    localparam int SUB   = SLOT >> BRIGHT_BITS;
    localparam int S_W   = clog2_safe(SLOT);
    localparam int D_W   = clog2_safe(DIGITS);

    if (SLOT < PWM_N || (SLOT % PWM_N) != 0) begin : g_bad_slot
        $error("hexscan_display: SLOT must be a non-zero multiple of 2**BRIGHT_BITS");
    end

    logic [S_W-1:0]         r_s;
    logic [D_W-1:0]         r_d;
    logic [4*DIGITS-1:0]    r_sh_value;
    logic [DIGITS-1:0]      r_sh_dots;
    logic [DIGITS-1:0]      r_sh_en;
    logic [BRIGHT_BITS-1:0] r_sh_bright;
    logic                   r_sh_lz;
    logic [SEG_W-1:0]       r_seg;
    logic                   r_dp;
    logic [DIGITS-1:0]      r_sel;
    logic                   r_tick;

    logic                   w_slot_end;
    logic                   w_frame_end;
    logic [S_W-1:0]         w_sub;
    logic [3:0]             w_nyb;
    logic [SEG_W-1:0]       w_glyph;
    logic [DIGITS-1:0]      w_blank;
    logic                   w_blank_d;
    logic                   w_blink_dark;
    logic                   w_on;
    logic                   w_drive;

    assign w_slot_end  = (r_s == S_W'(SLOT - 1));
    assign w_frame_end = w_slot_end && (r_d == D_W'(DIGITS - 1));

    assign w_sub = r_s / S_W'(SUB);
    assign w_nyb = r_sh_value[4*r_d +: 4];

    hexseg_decode u_dec (
        .i_nybble (w_nyb),
        .o_seg    (w_glyph)
    );

    // Digit k is a leading zero when it and every nybble above it are zero; digit 0 always shows.
    always_comb begin
        w_blank = '0;
        for (int k = 1; k < DIGITS; k++)
            w_blank[k] = r_sh_lz && ((r_sh_value >> (4 * k)) == '0);
    end

    assign w_blank_d = w_blank[r_d];

`ifdef HEXSCAN_BLINK_EN
    localparam int BF_W = clog2_safe(BLINK_FRAMES);

    logic [BF_W-1:0]   r_bcnt;
    logic              r_boff;
    logic [DIGITS-1:0] r_sh_blink;

    always_ff @(posedge clk or negedge rstbtn) begin
        if (!rstbtn) begin
            r_bcnt     <= '0;
            r_boff     <= 1'b0;
            r_sh_blink <= '0;
        end else if (w_frame_end) begin
            r_sh_blink <= blink;
            if (r_bcnt == BF_W'(BLINK_FRAMES - 1)) begin
                r_bcnt <= '0;
                r_boff <= ~r_boff;
            end else begin
                r_bcnt <= r_bcnt + 1'b1;
            end
        end
    end

    assign w_blink_dark = r_boff && r_sh_blink[r_d];
`else
    assign w_blink_dark = 1'b0;
`endif

    // A blanked digit still gets its select driven when its decimal point is requested.
    assign w_on    = (w_sub < S_W'(r_sh_bright)) && r_sh_en[r_d] && !w_blink_dark;
    assign w_drive = w_on && (!w_blank_d || r_sh_dots[r_d]);

    always_ff @(posedge clk or negedge rstbtn) begin
        if (!rstbtn) begin
            r_s         <= '0;
            r_d         <= '0;
            r_sh_value  <= '0;
            r_sh_dots   <= '0;
            r_sh_en     <= '0;
            r_sh_bright <= '0;
            r_sh_lz     <= 1'b0;
            r_seg       <= '0;
            r_dp        <= 1'b0;
            r_sel       <= '1;
            r_tick      <= 1'b0;
        end else begin
            r_s <= w_slot_end ? '0 : r_s + 1'b1;
            if (w_slot_end)
                r_d <= w_frame_end ? '0 : r_d + 1'b1;
            if (w_frame_end) begin
                r_sh_value  <= value;
                r_sh_dots   <= dots;
                r_sh_en     <= digit_en;
                r_sh_bright <= brightness;
                r_sh_lz     <= lz_blank;
            end
            r_tick <= (r_s == '0) && (r_d == '0);
            r_seg  <= (w_drive && !w_blank_d) ? w_glyph : '0;
            r_dp   <= w_drive && r_sh_dots[r_d];
            r_sel  <= w_drive ? ~(DIGITS'(1) << r_d) : '1;
        end
    end

    assign segment    = r_seg;
    assign dp         = r_dp;
    assign digitsel   = r_sel;
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_hexscan_display.sv
// Bench for hexscan_display: directed scenarios with hand-counted frame tallies plus random inputs,
// every output checked each cycle against a frame-position model of the display.
module tb_hexscan_display;

    localparam int FRAME = 64;
    localparam int SLOT  = 16;
    localparam int BF    = 2;

    logic        clk = 1'b0;
    logic        rstbtn = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dots = '0;
    logic [3:0]  digit_en = '0;
    logic [3:0]  brightness = '0;
    logic        lz_blank = 1'b0;
`ifdef HEXSCAN_BLINK_EN
    logic [3:0]  blink = '0;
    int          on0 [4];
`endif
    logic [6:0]  segment;
    logic        dp;
    logic [3:0]  digitsel;
    logic        frame_tick;

    int vectors = 0;
    int errs = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    hexscan_display #(
        .DIGITS(4), .CLK_HZ(16000), .REFRESH_HZ(250), .BRIGHT_BITS(4)
`ifdef HEXSCAN_BLINK_EN
        , .BLINK_FRAMES(BF)
`endif
    ) dut (
        .clk        (clk),
        .rstbtn     (rstbtn),
        .value      (value),
        .dots       (dots),
        .digit_en   (digit_en),
        .brightness (brightness),
        .lz_blank   (lz_blank),
`ifdef HEXSCAN_BLINK_EN
        .blink      (blink),
`endif
        .segment    (segment),
        .dp         (dp),
        .digitsel   (digitsel),
        .frame_tick (frame_tick)
    );

    logic [6:0] HEXT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: k = clock edges since reset release; outputs after edge k show frame position k-1.
    int          k;
    logic [15:0] sh_v;
    logic [3:0]  sh_dots, sh_en, sh_br, sh_blink;
    logic        sh_lz;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_sel;
    logic        e_tick;

    always @(posedge clk or negedge rstbtn) begin
        int pos, fr, dg, nyb;
        logic blanked, on, drive;
        if (!rstbtn) begin
            k = 0;
            sh_v = '0; sh_dots = '0; sh_en = '0; sh_br = '0; sh_blink = '0; sh_lz = 1'b0;
            e_seg = '0; e_dp = 1'b0; e_sel = 4'hF; e_tick = 1'b0;
        end else begin
            k++;
            pos = (k - 1) % FRAME;
            fr  = (k - 1) / FRAME;
            dg  = pos / SLOT;
            nyb = int'((sh_v >> (4 * dg)) & 16'hF);
            blanked = sh_lz && (dg != 0) && ((sh_v >> (4 * dg)) == 16'h0);
            on = ((pos % SLOT) < int'(sh_br)) && sh_en[dg];
            if (((fr / BF) % 2) == 1 && sh_blink[dg]) on = 1'b0;
            drive  = on && (!blanked || sh_dots[dg]);
            e_seg  = (drive && !blanked) ? HEXT[nyb] : 7'h00;
            e_dp   = drive && sh_dots[dg];
            e_sel  = drive ? ~(4'b0001 << dg) : 4'hF;
            e_tick = (pos == 0);
            if ((k % FRAME) == 0) begin
                sh_v = value; sh_dots = dots; sh_en = digit_en; sh_br = brightness; sh_lz = lz_blank;
`ifdef HEXSCAN_BLINK_EN
                sh_blink = blink;
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("segment", int'(segment), int'(e_seg));
            chk("dp", int'(dp), int'(e_dp));
            chk("digitsel", int'(digitsel), int'(e_sel));
            chk("frame_tick", int'(frame_tick), int'(e_tick));
        end
    end

    logic [3:0] lg_sel [FRAME];
    logic [6:0] lg_seg [FRAME];
    logic       lg_dp  [FRAME];

    task automatic sync_tick();
        int n = 0;
        @(negedge clk);
        while (frame_tick !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (frame_tick !== 1'b1) chk("tick_wait", 0, 1);
    endtask

    // New inputs are guaranteed to be on display by the second frame start.
    task automatic settle();
        sync_tick();
        sync_tick();
    endtask

    task automatic grab();
        for (int i = 0; i < FRAME; i++) begin
            if (i != 0) @(negedge clk);
            lg_sel[i] = digitsel;
            lg_seg[i] = segment;
            lg_dp[i]  = dp;
        end
    endtask

    function automatic int cnt(input logic [3:0] sel, input logic [6:0] seg, input logic d);
        int c = 0;
        for (int i = 0; i < FRAME; i++)
            if (lg_sel[i] == sel && lg_seg[i] == seg && lg_dp[i] == d) c++;
        return c;
    endfunction

    function automatic int cnt_sel(input logic [3:0] sel);
        int c = 0;
        for (int i = 0; i < FRAME; i++)
            if (lg_sel[i] == sel) c++;
        return c;
    endfunction

    initial begin
        int n06, n5b, npos, nbad, n;
        #2 rstbtn = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst_seg", int'(segment), 0);
        chk("rst_sel", int'(digitsel), 'hF);
        value = 16'h12AF; brightness = 4'd15; digit_en = 4'hF; dots = 4'h0; lz_blank = 1'b0;
        repeat (2) @(negedge clk);
        rstbtn = 1'b1;

        // Scenario 1: reset mid-frame while a digit is lit
        repeat (94) @(negedge clk);
        chk("s1_lit_before_rst", int'(digitsel), 'hD);
        #3 rstbtn = 1'b0;
        #1;
        chk("s1_rst_seg", int'(segment), 0);
        chk("s1_rst_dp", int'(dp), 0);
        chk("s1_rst_sel", int'(digitsel), 'hF);
        chk("s1_rst_tick", int'(frame_tick), 0);
        repeat (2) @(negedge clk);
        rstbtn = 1'b1;
        sync_tick(); grab();
        chk("s1_first_frame_dark", cnt_sel(4'hF), 64);
        sync_tick(); grab();
        chk("s1_d0", cnt(4'hE, 7'h71, 1'b0), 15);
        chk("s1_d1", cnt(4'hD, 7'h77, 1'b0), 15);
        chk("s1_d2", cnt(4'hB, 7'h5B, 1'b0), 15);
        chk("s1_d3", cnt(4'h7, 7'h06, 1'b0), 15);
        chk("s1_dark", cnt(4'hF, 7'h00, 1'b0), 4);

        // Scenario 2: PWM duty
        brightness = 4'd4;
        settle(); grab();
        chk("s2_d0", cnt(4'hE, 7'h71, 1'b0), 4);
        chk("s2_d3", cnt(4'h7, 7'h06, 1'b0), 4);
        npos = 0;
        for (int i = 0; i < FRAME; i++)
            if (lg_sel[i] != 4'hF && (i % SLOT) < 4) npos++;
        chk("s2_lit_slots_0_3", npos, 16);
        brightness = 4'd0;
        settle(); grab();
        chk("s2_bright0_dark", cnt_sel(4'hF), 64);

        // Scenario 3: leading-zero blanking
        brightness = 4'd15; lz_blank = 1'b1; value = 16'h0050;
        settle(); grab();
        chk("s3a_d3", cnt_sel(4'h7), 0);
        chk("s3a_d2", cnt_sel(4'hB), 0);
        chk("s3a_d1", cnt(4'hD, 7'h6D, 1'b0), 15);
        chk("s3a_d0", cnt(4'hE, 7'h3F, 1'b0), 15);
        value = 16'h0000;
        settle(); grab();
        chk("s3b_d0", cnt(4'hE, 7'h3F, 1'b0), 15);
        chk("s3b_dark", cnt_sel(4'hF), 49);
        value = 16'h0100; dots = 4'b1000;
        settle(); grab();
        chk("s3c_d3_dp_only", cnt(4'h7, 7'h00, 1'b1), 15);
        chk("s3c_d2", cnt(4'hB, 7'h06, 1'b0), 15);
        chk("s3c_d1", cnt(4'hD, 7'h3F, 1'b0), 15);
        chk("s3c_d0", cnt(4'hE, 7'h3F, 1'b0), 15);

        // Scenario 4: input change at s=7, d=2 must not tear the frame
        lz_blank = 1'b0; dots = 4'h0; value = 16'h1111;
        settle();
        repeat (38) @(negedge clk);
        value = 16'h2222;
        n06 = 0; n5b = 0;
        repeat (25) begin
            @(negedge clk);
            if (digitsel == 4'h7 && segment == 7'h06) n06++;
            if (segment == 7'h5B) n5b++;
        end
        chk("s4_rest_old_d3", n06, 15);
        chk("s4_rest_no_new", n5b, 0);
        @(negedge clk);
        chk("s4_tick", int'(frame_tick), 1);
        grab();
        chk("s4_new_d0", cnt(4'hE, 7'h5B, 1'b0), 15);
        chk("s4_new_d3", cnt(4'h7, 7'h5B, 1'b0), 15);

        // Scenario 5: per-digit enable and frame period
        value = 16'h12AF; digit_en = 4'b0101;
        settle(); grab();
        nbad = 0;
        for (int i = 0; i < FRAME; i++)
            if (!lg_sel[i][1] || !lg_sel[i][3]) nbad++;
        chk("s5_disabled_never_low", nbad, 0);
        chk("s5_d0", cnt(4'hE, 7'h71, 1'b0), 15);
        chk("s5_d2", cnt(4'hB, 7'h5B, 1'b0), 15);
        sync_tick();
        repeat (3) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (frame_tick !== 1'b1 && n < 200);
            chk("s5_tick_period", n, 64);
        end

`ifdef HEXSCAN_BLINK_EN
        // Scenario 6: blink with a two-frame phase
        digit_en = 4'hF; blink = 4'b0001;
        settle();
        for (int f = 0; f < 4; f++) begin
            if (f != 0) sync_tick();
            grab();
            on0[f] = cnt(4'hE, 7'h71, 1'b0);
            chk("s6_d1_unaffected", cnt(4'hD, 7'h77, 1'b0), 15);
        end
        chk("s6_d0_on_frames", int'(on0[0] == 15) + int'(on0[1] == 15) + int'(on0[2] == 15) + int'(on0[3] == 15), 2);
        chk("s6_d0_phase_flip", int'(on0[0] == on0[2]), 0);
        chk("s6_d0_phase_len", int'(on0[0] == on0[1] || on0[1] == on0[2]), 1);
`endif

        // Random inputs, including one asynchronous reset
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) begin
                value      = 16'($urandom);
                dots       = 4'($urandom);
                digit_en   = 4'($urandom);
                brightness = 4'($urandom);
                lz_blank   = 1'($urandom_range(0, 1));
`ifdef HEXSCAN_BLINK_EN
                blink      = 4'($urandom);
`endif
            end
            if (i == 700) begin
                #2 rstbtn = 1'b0;
                @(negedge clk);
                rstbtn = 1'b1;
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
